// File: rtl/sha256_host_master_if.sv
// Block/digest handshakes plus the sha256 core register bus.
// master = host initiator side, slave = upstream/consumer/core side.
interface sha256_host_master_if;
  logic         blk_valid;
  logic         blk_ready;
  logic [511:0] blk_data;
  logic         blk_first;
  logic         blk_mode;
  logic         dig_valid;
  logic         dig_ready;
  logic [255:0] dig_data;
  logic         err;
  logic         busy;
  logic         core_cs;
  logic         core_we;
  logic [7:0]   core_address;
  logic [31:0]  core_write_data;
  logic [31:0]  core_read_data;
  logic         core_error;

  modport master (
    input  blk_valid, blk_data, blk_first, blk_mode,
    input  dig_ready, core_read_data, core_error,
    output blk_ready, dig_valid, dig_data, err, busy,
    output core_cs, core_we, core_address, core_write_data
  );

  modport slave (
    output blk_valid, blk_data, blk_first, blk_mode,
    output dig_ready, core_read_data, core_error,
    input  blk_ready, dig_valid, dig_data, err, busy,
    input  core_cs, core_we, core_address, core_write_data
  );
endinterface

// File: rtl/sha256_host_master.sv
// sha256_host_master: drives the sha256 core register map for one block,
// writing block and control, polling status, then reading the digest back.
module sha256_host_master #(
  parameter int POLL_TIMEOUT = 1024,
  parameter int GAP_CYCLES   = 1
) (
  input logic clk,
  input logic reset_n,
  sha256_host_master_if.master bus
);
  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] WR_BLK  = 3'd1;
  localparam logic [2:0] WR_CTRL = 3'd2;
  localparam logic [2:0] GAP     = 3'd3;
  localparam logic [2:0] POLL    = 3'd4;
  localparam logic [2:0] RD_DIG  = 3'd5;
  localparam logic [2:0] OUT     = 3'd6;

  localparam int PW = $clog2(POLL_TIMEOUT) + 1;

  localparam logic [7:0] A_BLK  = 8'h10;
  localparam logic [7:0] A_CTRL = 8'h08;
  localparam logic [7:0] A_STAT = 8'h09;
  localparam logic [7:0] A_DIG  = 8'h20;

  logic [2:0]    state;
  logic [479:0]  blk_q;
  logic          first_q;
  logic          mode_q;
  logic [3:0]    cnt;
  logic [3:0]    gap_cnt;
  logic [PW-1:0] poll_cnt;
  logic [31:0]   ctrl_word;
  logic [31:0]   dig_word;
  logic          abort;

  // MODE adds 0x04; a first block starts with INIT, otherwise NEXT
  assign ctrl_word = {29'h0, mode_q, ~first_q, first_q};

  // SHA-224 has seven digest words, so the eighth slot is zeroed
  assign dig_word = (cnt[2:0] == 3'd7 && !mode_q)
                  ? 32'h0 : bus.core_read_data;

  assign abort    = bus.core_cs & bus.core_error;
  assign bus.busy = (state != IDLE);

  // Access sequencer: every bus output is set up one edge ahead
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state               <= IDLE;
      blk_q               <= '0;
      first_q             <= 1'b0;
      mode_q              <= 1'b0;
      cnt                 <= '0;
      gap_cnt             <= '0;
      poll_cnt            <= '0;
      bus.blk_ready       <= 1'b0;
      bus.dig_valid       <= 1'b0;
      bus.dig_data        <= '0;
      bus.err             <= 1'b0;
      bus.core_cs         <= 1'b0;
      bus.core_we         <= 1'b0;
      bus.core_address    <= '0;
      bus.core_write_data <= '0;
    end else if (abort) begin
      bus.err       <= 1'b1;
      bus.core_cs   <= 1'b0;
      bus.core_we   <= 1'b0;
      bus.blk_ready <= 1'b1;
      state         <= IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.blk_valid && bus.blk_ready) begin
            blk_q               <= bus.blk_data[479:0];
            first_q             <= bus.blk_first;
            mode_q              <= bus.blk_mode;
            bus.err             <= 1'b0;
            bus.blk_ready       <= 1'b0;
            bus.core_cs         <= 1'b1;
            bus.core_we         <= 1'b1;
            bus.core_address    <= A_BLK;
            bus.core_write_data <= bus.blk_data[511:480];
            cnt                 <= '0;
            state               <= WR_BLK;
          end else begin
            bus.blk_ready <= 1'b1;
          end
        end
        WR_BLK: begin
          if (cnt == 4'd15) begin
            bus.core_address    <= A_CTRL;
            bus.core_write_data <= ctrl_word;
            state               <= WR_CTRL;
          end else begin
            bus.core_address    <= bus.core_address + 8'd1;
            bus.core_write_data <= blk_q[479:448];
            blk_q               <= {blk_q[447:0], 32'h0};
          end
          cnt <= cnt + 4'd1;
        end
        WR_CTRL: begin
          bus.core_cs <= 1'b0;
          bus.core_we <= 1'b0;
          gap_cnt     <= '0;
          state       <= GAP;
        end
        GAP: begin
          if (gap_cnt == 4'(GAP_CYCLES - 1)) begin
            bus.core_cs      <= 1'b1;
            bus.core_we      <= 1'b0;
            bus.core_address <= A_STAT;
            poll_cnt         <= '0;
            state            <= POLL;
          end else begin
            gap_cnt <= gap_cnt + 4'd1;
          end
        end
        POLL: begin
          if (bus.core_read_data[1]) begin
            bus.core_address <= A_DIG;
            cnt              <= '0;
            state            <= RD_DIG;
          end else if (poll_cnt == PW'(POLL_TIMEOUT - 1)) begin
            bus.err       <= 1'b1;
            bus.core_cs   <= 1'b0;
            bus.blk_ready <= 1'b1;
            state         <= IDLE;
          end else begin
            poll_cnt <= poll_cnt + 1'b1;
          end
        end
        RD_DIG: begin
          bus.dig_data <= {bus.dig_data[223:0], dig_word};
          if (cnt[2:0] == 3'd7) begin
            bus.core_cs   <= 1'b0;
            bus.dig_valid <= 1'b1;
            state         <= OUT;
          end else begin
            bus.core_address <= bus.core_address + 8'd1;
          end
          cnt <= cnt + 4'd1;
        end
        OUT: begin
          if (bus.dig_ready) begin
            bus.dig_valid <= 1'b0;
            bus.blk_ready <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sha256_host_master.sv
// Bench for sha256_host_master with a behavioural sha256 core model
// and a plain-arithmetic SHA-256 reference.
module tb_sha256_host_master;
  localparam int TO  = 8;
  localparam int GAP = 2;

  localparam logic [255:0] IV256 = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
  localparam logic [255:0] IV224 = {
    32'hc1059ed8, 32'h367cd507, 32'h3070dd17, 32'hf70e5939,
    32'hffc00b31, 32'h68581511, 32'h64f98fa7, 32'hbefa4fa4};

  localparam logic [31:0] K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  sha256_host_master_if bus();

  sha256_host_master #(
    .POLL_TIMEOUT(TO),
    .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // core model state and knobs
  logic [511:0] core_blk = '0;
  logic [255:0] core_h = '0;
  logic         computed = 1'b0;
  int           stat_delay = 0;
  int           cfg_delay = 0;
  logic         cfg_hang = 1'b0;
  logic [8:0]   err_addr = 9'h100;
  logic         status_valid;
  logic [40:0]  acc_log [$];

  function automatic logic [31:0] rotr(input logic [31:0] x,
                                       input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] sha_compress(
      input logic [255:0] hin, input logic [511:0] blk);
    logic [31:0] w [64];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
    for (int i = 0; i < 16; i++) w[i] = blk[511-32*i -: 32];
    for (int i = 16; i < 64; i++)
      w[i] = (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10))
           + w[i-7]
           + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
           + w[i-16];
    {a, b, c, d, e, f, g, hh} = hin;
    for (int i = 0; i < 64; i++) begin
      t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25))
         + ((e & f) ^ (~e & g)) + K[i] + w[i];
      t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22))
         + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1;
      d = c; c = b; b = a; a = t1 + t2;
    end
    return {hin[255:224] + a, hin[223:192] + b,
            hin[191:160] + c, hin[159:128] + d,
            hin[127:96] + e,  hin[95:64] + f,
            hin[63:32] + g,   hin[31:0] + hh};
  endfunction

  function automatic logic [255:0] trunc(input logic [255:0] h,
                                         input logic md);
    return md ? h : {h[255:32], 32'h0};
  endfunction

  assign status_valid = computed && !cfg_hang && (stat_delay == 0);
  assign bus.core_error = bus.core_cs &&
                          ({1'b0, bus.core_address} == err_addr);

  always_comb begin
    bus.core_read_data = 32'h0;
    if (bus.core_address[7:4] == 4'h1)
      bus.core_read_data =
        core_blk[511-32*int'(bus.core_address[3:0]) -: 32];
    else if (bus.core_address == 8'h09)
      bus.core_read_data = {30'h0, status_valid, 1'b1};
    else if (bus.core_address[7:3] == 5'b00100)
      bus.core_read_data =
        core_h[255-32*int'(bus.core_address[2:0]) -: 32];
  end

  always @(posedge clk) begin
    if (bus.core_cs) begin
      acc_log.push_back({bus.core_we, bus.core_address,
        bus.core_we ? bus.core_write_data : bus.core_read_data});
      if (bus.core_we && bus.core_address[7:4] == 4'h1)
        core_blk[511-32*int'(bus.core_address[3:0]) -: 32]
          <= bus.core_write_data;
      if (bus.core_we && bus.core_address == 8'h08) begin
        computed   <= 1'b1;
        stat_delay <= cfg_delay;
        if (bus.core_write_data[0])
          core_h <= sha_compress(
            bus.core_write_data[2] ? IV256 : IV224, core_blk);
        else if (bus.core_write_data[1])
          core_h <= sha_compress(core_h, core_blk);
      end
      if (!bus.core_we && bus.core_address == 8'h09 &&
          computed && stat_delay > 0)
        stat_delay <= stat_delay - 1;
    end
  end

  task automatic check(input string tag, input logic [255:0] got,
                       input logic [255:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // kind 0 = any access, 1 = writes, 2 = STATUS reads
  function automatic int count_acc(input int s, input int kind);
    int n = 0;
    for (int i = s; i < acc_log.size(); i++) begin
      if (kind == 0) n++;
      else if (kind == 1 && acc_log[i][40]) n++;
      else if (kind == 2 && !acc_log[i][40] &&
               acc_log[i][39:32] == 8'h09) n++;
    end
    return n;
  endfunction

  task automatic send_block(input logic [511:0] d, input logic first,
                            input logic md, output int s);
    int t = 0;
    while (!bus.blk_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    check("blk_ready_wait", 256'(bus.blk_ready), 256'(1));
    s = acc_log.size();
    bus.blk_valid = 1'b1;
    bus.blk_data  = d;
    bus.blk_first = first;
    bus.blk_mode  = md;
    @(negedge clk);
    bus.blk_valid = 1'b0;
    bus.blk_data  = {16{$urandom()}};
    bus.blk_first = 1'($urandom());
    bus.blk_mode  = 1'($urandom());
    check("accept_bus",
      256'({bus.core_cs, bus.core_we, bus.core_address,
            bus.blk_ready, bus.err, bus.busy}),
      256'({1'b1, 1'b1, 8'h10, 1'b0, 1'b0, 1'b1}));
  endtask

  task automatic wait_digest(output logic [255:0] dg, output int lat);
    lat = 1;
    while (!bus.dig_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    check("dig_valid_seen", 256'(bus.dig_valid), 256'(1));
    dg = bus.dig_data;
  endtask

  task automatic take_digest(input int stall);
    repeat (stall) @(negedge clk);
    bus.dig_ready = 1'b1;
    @(negedge clk);
    bus.dig_ready = 1'b0;
    check("handshake",
      256'({bus.dig_valid, bus.blk_ready, bus.busy}),
      256'({1'b0, 1'b1, 1'b0}));
  endtask

  task automatic wait_idle(output logic saw);
    int t = 0;
    saw = 1'b0;
    while (bus.busy && t < 300) begin
      if (bus.dig_valid) saw = 1'b1;
      @(negedge clk);
      t++;
    end
    check("idle_reached", 256'(bus.busy), 256'(0));
  endtask

  task automatic check_writes(input int s, input logic [511:0] d,
                              input logic [31:0] ctrl);
    int bad = 0;
    logic [40:0] ent;
    for (int i = 0; i < 16; i++) begin
      ent = (s + i < acc_log.size()) ? acc_log[s+i] : '0;
      if (ent !== {1'b1, 8'(8'h10 + i), d[511-32*i -: 32]}) bad++;
    end
    check("blk_writes", 256'(bad), 256'(0));
    ent = (s + 16 < acc_log.size()) ? acc_log[s+16] : '0;
    check("ctrl_write", 256'(ent), 256'({1'b1, 8'h08, ctrl}));
    check("n_writes", 256'(count_acc(s, 1)), 256'(17));
  endtask

  initial begin
    logic [511:0] tv, b0, b1, b;
    logic [255:0] dg, dg0, hx;
    logic         saw, md;
    int           s, lat, nb, dly, bad;

    reset_n       = 1'b0;
    bus.blk_valid = 1'b0;
    bus.blk_data  = '0;
    bus.blk_first = 1'b0;
    bus.blk_mode  = 1'b0;
    bus.dig_ready = 1'b0;
    tv = {32'h74616e70, 32'h68616e64, 32'h65768000,
          384'h0, 32'h00000050};

    #12;
    check("rst_blk_ready", 256'(bus.blk_ready), 256'(0));
    check("rst_dig_valid", 256'(bus.dig_valid), 256'(0));
    check("rst_dig_data", bus.dig_data, 256'(0));
    check("rst_err", 256'(bus.err), 256'(0));
    check("rst_busy", 256'(bus.busy), 256'(0));
    check("rst_cs_we", 256'({bus.core_cs, bus.core_we}), 256'(0));
    check("rst_addr", 256'(bus.core_address), 256'(0));
    check("rst_wdata", 256'(bus.core_write_data), 256'(0));
    @(negedge clk);
    reset_n = 1'b1;
    check("ready_pre_edge", 256'(bus.blk_ready), 256'(0));
    @(negedge clk);
    check("ready_post_rst", 256'(bus.blk_ready), 256'(1));

    // known SHA-256 vector, minimum latency
    cfg_delay = 0;
    send_block(tv, 1'b1, 1'b1, s);
    wait_digest(dg, lat);
    check("tan_const", dg, 256'h85e9a47fc5dc216f9b3ff562488d35c93210cfd8d265688dfeb0612c56f76886);
    check("tan_model", dg, sha_compress(IV256, tv));
    check("tan_lat", 256'(lat), 256'(27 + GAP));
    check("tan_err", 256'(bus.err), 256'(0));
    check("tan_polls", 256'(count_acc(s, 2)), 256'(1));
    check_writes(s, tv, 32'h05);
    take_digest(0);

    // SHA-224 mode: CTRL 0x01, last word zeroed
    send_block(tv, 1'b1, 1'b0, s);
    wait_digest(dg, lat);
    check_writes(s, tv, 32'h01);
    check("s224_word7", 256'(dg[31:0]), 256'(0));
    check("s224_model", dg, trunc(sha_compress(IV224, tv), 1'b0));
    take_digest(1);

    // two-block message: INIT then NEXT
    for (int j = 0; j < 16; j++) begin
      b0[511-32*j -: 32] = $urandom();
      b1[511-32*j -: 32] = $urandom();
    end
    b1[31:0] = 32'h280;
    cfg_delay = $urandom_range(0, TO - 1);
    send_block(b0, 1'b1, 1'b1, s);
    wait_digest(dg0, lat);
    check_writes(s, b0, 32'h05);
    check("blk0_digest", dg0, sha_compress(IV256, b0));
    take_digest(0);
    send_block(b1, 1'b0, 1'b1, s);
    wait_digest(dg, lat);
    check_writes(s, b1, 32'h06);
    check("blk1_digest", dg,
          sha_compress(sha_compress(IV256, b0), b1));
    take_digest(2);

    // STATUS never valid: poll limit aborts
    cfg_hang = 1'b1;
    send_block(tv, 1'b1, 1'b1, s);
    wait_idle(saw);
    check("to_polls", 256'(count_acc(s, 2)), 256'(TO));
    check("to_err", 256'(bus.err), 256'(1));
    check("to_no_digest", 256'(saw), 256'(0));
    cfg_hang = 1'b0;
    cfg_delay = 0;
    send_block(tv, 1'b1, 1'b1, s);
    wait_digest(dg, lat);
    check("to_recover", dg, sha_compress(IV256, tv));
    take_digest(0);

    // error on a successful STATUS read wins
    err_addr = 9'h009;
    send_block(tv, 1'b1, 1'b1, s);
    wait_idle(saw);
    check("perr_err", 256'(bus.err), 256'(1));
    check("perr_no_digest", 256'(saw), 256'(0));
    check("perr_polls", 256'(count_acc(s, 2)), 256'(1));

    // error on the write to 0x13
    err_addr = 9'h013;
    send_block(tv, 1'b1, 1'b1, s);
    wait_idle(saw);
    check("werr_err", 256'(bus.err), 256'(1));
    check("werr_acc", 256'(count_acc(s, 0)), 256'(4));
    repeat (5) @(negedge clk);
    check("werr_quiet", 256'(count_acc(s, 0)), 256'(4));
    check("werr_ready", 256'(bus.blk_ready), 256'(1));
    err_addr = 9'h100;

    // reset in the middle of the block writes
    send_block(tv, 1'b1, 1'b1, s);
    repeat (3) @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst",
      256'({bus.core_cs, bus.busy, bus.blk_ready, bus.err}),
      256'(0));
    @(negedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    check("mid_rst_ready", 256'(bus.blk_ready), 256'(1));

    // randomized messages against the reference
    for (int m = 0; m < 6; m++) begin
      md = 1'($urandom_range(0, 1));
      nb = $urandom_range(1, 3);
      for (int k = 0; k < nb; k++) begin
        for (int j = 0; j < 16; j++) b[511-32*j -: 32] = $urandom();
        dly = $urandom_range(0, TO - 1);
        cfg_delay = dly;
        hx = (k == 0) ? sha_compress(md ? IV256 : IV224, b)
                      : sha_compress(hx, b);
        send_block(b, k == 0, md, s);
        wait_digest(dg, lat);
        check_writes(s, b, {29'h0, md, k != 0, k == 0});
        check("rnd_digest", dg, trunc(hx, md));
        check("rnd_lat", 256'(lat), 256'(27 + GAP + dly));
        check("rnd_polls", 256'(count_acc(s, 2)), 256'(dly + 1));
        if (m == 0 && k == 0) begin
          bad = 0;
          for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.dig_valid !== 1'b1 || bus.dig_data !== dg ||
                bus.blk_ready !== 1'b0) bad++;
          end
          check("hold_stable", 256'(bad), 256'(0));
          take_digest(0);
        end else begin
          take_digest($urandom_range(0, 3));
        end
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/sha256_host_master.md
Name: sha256_host_master

Overview:
Hardware bus initiator that drives the sha256 core's 8-bit-address register interface in place of a software host. It accepts a 512-bit block with first/next and mode flags over a valid/ready handshake. It then writes the block words and the control word, polls status until the digest is valid, reads the 8 digest words, and presents the 256-bit digest over a second valid/ready handshake. It sits between a message-padding/streaming front end and the sha256 core.

Parameters:
POLL_TIMEOUT, 1024, maximum number of status reads per block before the block is aborted with an error.
GAP_CYCLES, 1, number of idle bus cycles between the control write and the first status read; range 1..15.

Ports:
clk  in  1  system clock, rising edge.
reset_n  in  1  asynchronous, active-low reset.
blk_valid  in  1  block offer.
blk_ready  out  1  master can accept a block.
blk_data  in  512  message block; bits [511:480] are word 0.
blk_first  in  1  1 = start a new message (INIT), 0 = continue the message (NEXT).
blk_mode  in  1  1 = SHA-256, 0 = SHA-224.
dig_valid  out  1  digest available.
dig_ready  in  1  consumer accepts the digest.
dig_data  out  256  digest; word 0 at [255:224].
err  out  1  sticky error flag; cleared when the next block is accepted.
busy  out  1  high in every state except IDLE.
core_cs  out  1  core chip select.
core_we  out  1  core write enable.
core_address  out  8  core register address.
core_write_data  out  32  core write data.
core_read_data  in  32  core read data, combinational from core_address.
core_error  in  1  core access error.

Behaviour:
- Reset values: blk_ready=0, dig_valid=0, dig_data=0, err=0, busy=0, core_cs=0, core_we=0, core_address=0, core_write_data=0. State is IDLE. On the first cycle after reset, blk_ready=1.
- Every bus access lasts exactly one cycle, with core_cs=1 and all bus outputs registered. Read data is captured at the rising edge that ends the access. Between accesses, core_cs=0 and core_we=0.
- Register map: block words at 0x10..0x1F, CTRL at 0x08 (INIT=0x01, NEXT=0x02, MODE=0x04), STATUS at 0x09 (bit0 = ready, bit1 = valid), digest words at 0x20..0x27.
- IDLE: blk_ready=1. When blk_valid & blk_ready, the master latches blk_data, blk_first and blk_mode, clears err, and goes to WR_BLK.
- WR_BLK: 16 consecutive write cycles, addresses 0x10..0x1F, data taken from the latched block word i. A 4-bit counter wraps at 15, then the FSM goes to WR_CTRL.
- WR_CTRL: one write to 0x08 with data = (mode ? 0x04 : 0) + (first ? 0x01 : 0x02). The FSM then goes to GAP.
- GAP: GAP_CYCLES idle cycles, then POLL.
- POLL: one STATUS read per cycle.
  - Captured bit1=1: go to RD_DIG.
  - Captured bit1=0: increment the poll counter and stay in POLL.
  - Poll counter reaches POLL_TIMEOUT: set err and go to IDLE; no digest is produced.
- RD_DIG: 8 consecutive reads of 0x20..0x27, each stored into dig_data word i. In SHA-224 mode, word 7 is stored as 0. The FSM then goes to OUT.
- OUT: dig_valid=1 and dig_data is stable until dig_valid & dig_ready. On the handshake edge, dig_valid=0 and the FSM goes to IDLE. blk_ready is 0 while in OUT.
- Minimum latency, counting the block-accept edge as cycle 0:
  - writes on cycles 1..17;
  - first poll on cycle 18+GAP_CYCLES;
  - if that poll succeeds, dig_valid rises at cycle 27+GAP_CYCLES.
- core_error sampled 1 during any access: set err, finish the current access, drop core_cs, and go to IDLE. No digest is produced. A core_error seen in the same cycle as a successful STATUS read also aborts, so error takes priority.
- An asynchronous reset at any point immediately returns all outputs to their reset values, including mid-write. The partially written core state is not recovered; the upstream source must resend the message from a blk_first=1 block.
- blk_data changes while the master is busy are ignored, because the block is latched at accept.

Test Plan:
- Reset, then a single block with mode=1, first=1, blk_data = 74616e7068616e646576 followed by 0x80 and zero padding, with length word 0x50 ("tanphandev"), connected to the real sha256 core -> dig_data = 85e9a47fc5dc216f9b3ff562488d35c93210cfd8d265688dfeb0612c56f76886, err=0; a bus monitor logs exactly 16 writes at 0x10..0x1F, then one write of 0x05 to 0x08.
- Two blocks, mode=1: block0 00a0112e_535d5123_... with first=1, then block1 94a1141e_85d82e64_..._00000280 with first=0 -> CTRL writes 0x05 then 0x06; final digest = 0f16950a558436f808889fa4bc20e178df3a0ce02b76700ff19912afbc6a2a6a.
- Same "tanphandev" block with mode=0 -> CTRL write = 0x01 and dig_data[31:0]=0.
- Hold dig_ready=0 for 20 cycles after dig_valid rises -> dig_valid stays 1 and dig_data is unchanged; blk_ready=0 throughout; on the handshake, blk_ready=1 the next cycle.
- Stub core that returns STATUS=0 forever, with POLL_TIMEOUT=8 -> exactly 8 reads of 0x09, then err=1, dig_valid never asserted, return to IDLE; the next accepted block clears err.
- Stub core that raises core_error on the write to 0x13 -> err=1, no further accesses, return to IDLE. Separately, assert reset_n=0 for one cycle during WR_BLK -> core_cs=0, busy=0 and blk_ready=0 immediately, and blk_ready=1 one cycle after release.
